// File: rtl/conv_same_seq.sv
// conv_same_seq: address/control sequencer for the "same"-mode convolution
// datapath. For each output k it clears the accumulator, walks the kernel
// index j over every tap, reads X[k+off-j]*Y[j] when that X index is in
// range, lets the last product drain through the MAC and then writes Z[k].
module conv_same_seq #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  size_x_i,
  input  logic [CNT_W-1:0]  size_y_i,
  output logic [ADDR_W-1:0] addr_x_o,
  output logic [ADDR_W-1:0] addr_y_o,
  output logic              rd_en_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              wr_z_o,
  output logic [ADDR_W-1:0] addr_z_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  sx, sy;
  logic [CNT_W-1:0]  k, j;
  logic [CNT_W-1:0]  off;
  logic [CNT_W-1:0]  sx_clamp, sy_clamp;
  logic signed [CNT_W:0] n;
  logic              n_in_range;
  logic              last_j, last_k;

  assign sx_clamp = (size_x_i > DEPTH) ? DEPTH : size_x_i;
  assign sy_clamp = (size_y_i > DEPTH) ? DEPTH : size_y_i;

  // Centre offset of the kernel; only meaningful while sy >= 1 (i.e. in a run)
  assign off = (sy - 1'b1) >> 1;

  // One extra bit so that k+off-j can go negative without aliasing
  assign n = $signed({1'b0, k}) + $signed({1'b0, off}) - $signed({1'b0, j});
  assign n_in_range = !n[CNT_W] && (n < $signed({1'b0, sx}));

  assign last_j = (j == sy - 1'b1);
  assign last_k = (k == sx - 1'b1);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture clamped sizes when a run is accepted; later size changes are ignored
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sx <= '0;
      sy <= '0;
    end else if (state == S_IDLE && start_i) begin
      sx <= sx_clamp;
      sy <= sy_clamp;
    end
  end

  // Output index k and kernel index j
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k <= '0;
      j <= '0;
    end else begin
      case (state)
        S_IDLE:  k <= '0;
        S_INIT:  j <= '0;
        S_CALC:  j <= j + 1'b1;
        S_WRITE: if (!last_k) k <= k + 1'b1;
        default: ;
      endcase
    end
  end

  // Accumulate enable follows the read enable by the memory read latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_en_o <= 1'b0;
    end else begin
      acc_en_o <= rd_en_o;
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_nxt = state;
    addr_x_o  = '0;
    addr_y_o  = '0;
    rd_en_o   = 1'b0;
    acc_clr_o = 1'b0;
    wr_z_o    = 1'b0;
    addr_z_o  = '0;
    busy_o    = 1'b1;
    done_o    = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          if (sx_clamp == '0 || sy_clamp == '0) state_nxt = S_DONE;
          else                                  state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        acc_clr_o = 1'b1;
        state_nxt = S_CALC;
      end
      S_CALC: begin
        if (n_in_range) begin
          rd_en_o  = 1'b1;
          addr_x_o = n[ADDR_W-1:0];
          addr_y_o = j[ADDR_W-1:0];
        end
        if (last_j) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_z_o    = 1'b1;
        addr_z_o  = k[ADDR_W-1:0];
        state_nxt = last_k ? S_DONE : S_INIT;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy_o    = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_same_seq.sv
// Testbench for conv_same_seq: a cycle model pushes the expected output
// vector of every cycle of a run into a queue; a monitor pops and compares
// one entry per clock. Scenario tasks add latency and count checks.
module tb_conv_same_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [5:0] size_x_i, size_y_i;
  logic [4:0] addr_x_o, addr_y_o, addr_z_o;
  logic       rd_en_o, acc_clr_o, acc_en_o, wr_z_o, busy_o, done_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc, done_cyc;
  int n_rd, n_acc, n_clr, n_wr, n_busy;
  int z_log[$];
  logic [20:0] q[$];

  conv_same_seq #(.ADDR_W(5), .CNT_W(6)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .size_x_i (size_x_i),
    .size_y_i (size_y_i),
    .addr_x_o (addr_x_o),
    .addr_y_o (addr_y_o),
    .rd_en_o  (rd_en_o),
    .acc_clr_o(acc_clr_o),
    .acc_en_o (acc_en_o),
    .wr_z_o   (wr_z_o),
    .addr_z_o (addr_z_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [20:0] rec(input logic busy, done, clr, rd, acc, wr,
                                      input int ax, ay, az);
    return {busy, done, clr, rd, acc, wr, 5'(ax), 5'(ay), 5'(az)};
  endfunction

  function automatic logic [20:0] actual();
    return {busy_o, done_o, acc_clr_o, rd_en_o, acc_en_o, wr_z_o,
            addr_x_o, addr_y_o, (wr_z_o ? addr_z_o : 5'd0)};
  endfunction

  // Expected per-cycle outputs of one run, starting the cycle after start
  task automatic push_run(input int sxr, input int syr);
    int sx, sy, off, n;
    logic prd, rd;
    sx = (sxr > 32) ? 32 : sxr;
    sy = (syr > 32) ? 32 : syr;
    prd = 1'b0;
    if (sx == 0 || sy == 0) begin
      q.push_back(rec(1, 1, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      off = (sy - 1) / 2;
      for (int k = 0; k < sx; k++) begin
        q.push_back(rec(1, 0, 1, 0, prd, 0, 0, 0, 0));
        prd = 1'b0;
        for (int jj = 0; jj < sy; jj++) begin
          n  = k + off - jj;
          rd = (n >= 0) && (n < sx);
          q.push_back(rec(1, 0, 0, rd, prd, 0, rd ? n : 0, rd ? jj : 0, 0));
          prd = rd;
        end
        q.push_back(rec(1, 0, 0, 0, prd, 0, 0, 0, 0));
        prd = 1'b0;
        q.push_back(rec(1, 0, 0, 0, 0, 1, 0, 0, k));
      end
      q.push_back(rec(1, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    q.push_back(rec(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge clk_i) begin
    logic [20:0] e;
    #1;
    cyc++;
    if (done_o) done_cyc = cyc;
    n_rd   += int'(rd_en_o);
    n_acc  += int'(acc_en_o);
    n_clr  += int'(acc_clr_o);
    n_wr   += int'(wr_z_o);
    n_busy += int'(busy_o);
    if (wr_z_o) z_log.push_back(int'(addr_z_o));
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (actual() !== e) begin
        bad++;
        $display("FAIL sb cyc=%0d actual=%h expected=%h", cyc, actual(), e);
      end
    end
  end

  task automatic launch(input int sxr, input int syr);
    @(negedge clk_i);
    push_run(sxr, syr);
    n_rd = 0; n_acc = 0; n_clr = 0; n_wr = 0; n_busy = 0;
    z_log.delete();
    done_cyc  = -1;
    start_cyc = cyc;
    start_i   = 1'b1;
    size_x_i  = 6'(sxr);
    size_y_i  = 6'(syr);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk_i);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=%0d entries left required=0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (actual() !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs actual=%h required=0", actual());
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_t1();
    launch(5, 3);
    wait_empty("t1");
    total++;
    if (done_cyc - start_cyc !== 31) begin
      bad++; $display("FAIL t1_latency actual=%0d required=31", done_cyc - start_cyc);
    end
    total++;
    if (n_rd !== 13) begin
      bad++; $display("FAIL t1_reads actual=%0d required=13", n_rd);
    end
    total++;
    if (z_log.size() !== 5) begin
      bad++; $display("FAIL t1_writes actual=%0d required=5", z_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (z_log[i] !== i) begin
          bad++; $display("FAIL t1_addr_z actual=%0d required=%0d", z_log[i], i);
        end
      end
    end
  endtask

  task automatic test_t2();
    launch(4, 4);
    wait_empty("t2");
    total++;
    if (n_rd !== 12 || n_acc !== 12) begin
      bad++; $display("FAIL t2_terms actual=%0d/%0d required=12/12", n_rd, n_acc);
    end
  endtask

  task automatic test_zero();
    launch(0, 3);
    wait_empty("t3a");
    total++;
    if (done_cyc - start_cyc !== 1 || n_busy !== 1) begin
      bad++; $display("FAIL t3a_timing actual=%0d/%0d required=1/1", done_cyc - start_cyc, n_busy);
    end
    total++;
    if (n_rd + n_clr + n_wr !== 0) begin
      bad++; $display("FAIL t3a_strobes actual=%0d required=0", n_rd + n_clr + n_wr);
    end
    launch(4, 0);
    wait_empty("t3b");
    total++;
    if (done_cyc - start_cyc !== 1 || n_busy !== 1) begin
      bad++; $display("FAIL t3b_timing actual=%0d/%0d required=1/1", done_cyc - start_cyc, n_busy);
    end
    total++;
    if (n_rd + n_clr + n_wr !== 0) begin
      bad++; $display("FAIL t3b_strobes actual=%0d required=0", n_rd + n_clr + n_wr);
    end
  endtask

  task automatic test_single();
    launch(1, 1);
    wait_empty("t4");
    total++;
    if (done_cyc - start_cyc !== 5) begin
      bad++; $display("FAIL t4_latency actual=%0d required=5", done_cyc - start_cyc);
    end
    total++;
    if (n_clr !== 1 || n_rd !== 1 || n_acc !== 1 || n_wr !== 1) begin
      bad++; $display("FAIL t4_counts actual=%0d%0d%0d%0d required=1111", n_clr, n_rd, n_acc, n_wr);
    end
  endtask

  task automatic test_midrun();
    launch(5, 3);
    repeat (4) @(negedge clk_i);
    start_i  = 1'b1;
    size_x_i = 6'd9;
    size_y_i = 6'd7;
    repeat (2) @(negedge clk_i);
    start_i = 1'b0;
    wait_empty("t5_restart");
    total++;
    if (done_cyc - start_cyc !== 31 || n_wr !== 5) begin
      bad++; $display("FAIL t5_ignore actual=%0d/%0d required=31/5", done_cyc - start_cyc, n_wr);
    end
    // Reset during CALC
    launch(5, 3);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    q.delete();
    #1;
    total++;
    if (actual() !== 21'd0) begin
      bad++; $display("FAIL t5_reset_outputs actual=%h required=0", actual());
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #2;
    total++;
    if (actual() !== 21'd0) begin
      bad++; $display("FAIL t5_idle_after_reset actual=%h required=0", actual());
    end
    launch(2, 2);
    wait_empty("t5_rerun");
    total++;
    if (done_cyc - start_cyc !== 11 || n_wr !== 2) begin
      bad++; $display("FAIL t5_rerun actual=%0d/%0d required=11/2", done_cyc - start_cyc, n_wr);
    end
  endtask

  task automatic test_clamp();
    launch(40, 3);
    wait_empty("t6");
    total++;
    if (done_cyc - start_cyc !== 193) begin
      bad++; $display("FAIL t6_latency actual=%0d required=193", done_cyc - start_cyc);
    end
    total++;
    if (z_log.size() !== 32) begin
      bad++; $display("FAIL t6_writes actual=%0d required=32", z_log.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        total++;
        if (z_log[i] !== i) begin
          bad++; $display("FAIL t6_addr_z actual=%0d required=%0d", z_log[i], i);
        end
      end
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    start_i  = 1'b0;
    size_x_i = '0;
    size_y_i = '0;
    test_reset();
    test_t1();
    test_t2();
    test_zero();
    test_single();
    test_midrun();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
